// File: rtl/uart_tx_piso_if.sv
// Character-side handshake and serial line of the PISO transmitter.
// Master drives load/data_in; slave (the transmitter) drives tx_out/busy/done.
interface uart_tx_piso_if #(
   parameter int DATA_BITS = 8
);
   logic                 load;
   logic [DATA_BITS-1:0] data_in;
   logic                 tx_out;
   logic                 busy;
   logic                 done;

   modport master (
      output load, data_in,
      input  tx_out, busy, done
   );

   modport slave (
      input  load, data_in,
      output tx_out, busy, done
   );
endinterface

// File: rtl/uart_tx_piso.sv
// Serial transmitter: start bit, DATA_BITS data LSB first, stop bit; each bit CLKS_PER_BIT clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, waiting for load
// S_START  | driving start bit (0)
// S_DATA   | driving r_shift[0], shifting right per bit
// S_PARITY | driving even parity of latched character
// S_STOP   | driving stop bit (1); done pulses on exit
module uart_tx_piso #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input logic            clk,
   input logic            reset,
   uart_tx_piso_if.slave  bus
);

   localparam int SW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               r_state;
   logic [SW-1:0]        r_sample;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx_out;
   logic                 r_busy;
   logic                 r_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   logic                 w_bit_end;
   logic [DATA_BITS-1:0] w_shift_nxt;

   assign w_bit_end   = (r_sample == SAMPLE_LAST);
   assign w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sample <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx_out <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE)
            r_sample <= '0;
         else
            r_sample <= w_bit_end ? '0 : r_sample + SW'(1);

         case (r_state)
            S_IDLE: begin
               if (bus.load) begin
                  r_shift  <= bus.data_in;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^bus.data_in;
`endif
                  r_state  <= S_START;
                  r_tx_out <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_bit    <= '0;
                  r_state  <= S_DATA;
                  r_tx_out <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     r_state  <= S_PARITY;
                     r_tx_out <= r_parity;
`else
                     r_state  <= S_STOP;
                     r_tx_out <= 1'b1;
`endif
                  end else begin
                     r_bit    <= r_bit + BW'(1);
                     r_shift  <= w_shift_nxt;
                     r_tx_out <= w_shift_nxt[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state  <= S_STOP;
                  r_tx_out <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_state  <= S_IDLE;
                  r_tx_out <= 1'b1;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_tx_out <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_out = r_tx_out;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

// File: doc/uart_tx_piso.md
Name: uart_tx_piso

Overview:
- Serial transmitter: parallel-in, serial-out (PISO). Sends 8-bit characters as asynchronous serial frames on a single line: one start bit (0), data LSB first, one stop bit (1).
- It is the transmit-side partner to the team's serial-in/parallel-out receive path.
- Bit timing uses a sample counter sized so each bit lasts exactly CLKS_PER_BIT clocks. This matches the receiver's 16-sample-per-bit counter at the default setting.
- Sits between the CPU-side character register and the off-chip line.

Parameters:
- CLKS_PER_BIT, 16, clock cycles each serial bit is held; must be ≥2.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load  input  1  request to send data_in; sampled only when busy=0
- data_in  input  DATA_BITS  character to transmit
- tx_out  output  1  serial line; idles high
- busy  output  1  high from the edge accepting load until the frame completes
- done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset values (reset sampled high at a clk edge):
  - tx_out=1, busy=0, done=0.
  - State IDLE; sample counter=0; bit counter=0; shift register=0.
- All outputs are registered. No combinational path from inputs to outputs.
- State machine:
  - IDLE
    - tx_out=1, busy=0.
    - load=1 at edge k: latch data_in into the shift register, go to START.
    - At edge k: tx_out←0, busy←1.
  - START
    - tx_out=0 for CLKS_PER_BIT cycles (edges k..k+CLKS_PER_BIT-1).
    - Then go to DATA with bit counter=0.
  - DATA
    - tx_out=shift[0] for CLKS_PER_BIT cycles, then shift right.
    - Bit counter increments 0..DATA_BITS-1.
    - After the last bit, go to STOP (or PARITY, see Optional Feature).
  - STOP
    - tx_out=1 for CLKS_PER_BIT cycles.
    - Then go to IDLE: busy←0, done←1 for exactly one cycle.
- Sample counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Held at 0 in IDLE.
- Frame length (edge k to the done edge): (DATA_BITS+2)×CLKS_PER_BIT cycles. Default: 160.
- load while busy=1: ignored. data_in changes have no effect on the frame in flight.
- Back-to-back frames:
  - load=1 in the cycle done=1 (IDLE, busy=0) is accepted.
  - Gives exactly one idle-high clock between the stop bit and the next start bit.
- load held continuously: a new frame starts each time IDLE is reached.
- Reset mid-frame:
  - At the next edge, tx_out=1, busy=0, done=0.
  - Frame is aborted with no done pulse; latched data is discarded.
- Reset and load in the same cycle: reset wins; no frame starts.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx_out = XOR of the latched character (even parity) for CLKS_PER_BIT cycles.
  - Frame length (DATA_BITS+3)×CLKS_PER_BIT. Default: 176.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset held 3 cycles, then released with load=0 for 50 cycles → tx_out=1, busy=0, done=0 throughout.
2. load=1 for one cycle with data_in=0xA5 → tx_out, each level held 16 cycles: 0 (start), 1,0,1,0,0,1,0,1 (data LSB first), 1 (stop). busy=1 for 160 cycles; done pulses once at edge k+160.
3. Frame 0xA5 in flight, load=1 with data_in=0xFF at bit 4 → ignored; serial stream identical to scenario 2; exactly one done pulse.
4. load held high with 0x00 then switched to 0x55 on the done cycle → frame 0x00, then one idle-high cycle, then start bit of 0x55 (data 1,0,1,0,1,0,1,0); two done pulses 161 cycles apart.
5. reset asserted one cycle during data bit 3 of 0x3C → tx_out=1 and busy=0 at the next edge, no done pulse. A subsequent load 0x81 transmits a clean full frame.
6. UART_TX_PARITY_EN defined, load 0x07 → parity bit=1 (three ones) held 16 cycles before stop; done at edge k+176. With 0x03: parity bit=0.
